// File: rtl/calc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : calc_pkg                                                |
// | Brief  : Shared encodings for the stack calculator: ALU opcodes,  |
// |          command FSM states and committed-action codes.          |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package calc_pkg;

    // ALU opcode encodings, matching the {btnl,btnc,btnr} switch layout
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    // Button bit positions inside the packed button vector
    localparam int BTN_EXEC = 0;
    localparam int BTN_PUSH = 1;
    localparam int BTN_POP  = 2;
    localparam int BTN_CLR  = 3;
    localparam int NUM_BTN  = 4;

    // Command FSM: IDLE accepts a press, HOLD waits for all buttons released
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Committed action, listed from highest to lowest priority
    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_CLR  = 3'd1,
        ACT_POP  = 3'd2,
        ACT_PUSH = 3'd3,
        ACT_EXEC = 3'd4
    } action_t;

endpackage
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : calc_alu                                                |
// | Brief  : Combinational WIDTH-bit ALU. ADD/SUB wrap and flag signed|
// |          overflow; shifts use the low log2(WIDTH) bits of b.      |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;

    assign shamt = b[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;
    assign slt   = $signed(a) < $signed(b);

    // Result mux and signed-overflow detection for ADD/SUB
    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_ADD: begin
                y   = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y   = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: y = {{(WIDTH-1){1'b0}}, slt};
            OP_SLL: y = a << shamt;
            OP_SRA: y = $signed(a) >>> shamt;
            OP_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : calc_stack                                              |
// | Brief  : Button-driven accumulator calculator with a DEPTH-entry  |
// |          LIFO operand stack and a release-gated command FSM that  |
// |          commits exactly one action per button press.             |
// |          Optional macro CALC_DEBOUNCE_EN inserts a DB_CYCLES      |
// |          saturating-counter debouncer on every button.            |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module calc_stack
    import calc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 op_sel,
    input  logic [WIDTH-1:0]           sw,
    input  logic                       btn_exec,
    input  logic                       btn_push,
    input  logic                       btn_pop,
    input  logic                       btn_clr,
    output logic [WIDTH-1:0]           led,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    // Elaboration-time parameter sanity checks
    if (WIDTH < 8) begin : g_chk_width
        $error("calc_stack: WIDTH must be >= 8");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("calc_stack: DEPTH must be a power of 2 and >= 2");
    end
    if (DB_CYCLES < 1) begin : g_chk_db
        $error("calc_stack: DB_CYCLES must be >= 1");
    end

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_lvl;
    logic [NUM_BTN-1:0] btn_q;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_clr, btn_pop, btn_push, btn_exec};

`ifdef CALC_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          lvl;

        // Flip the debounced level after DB_CYCLES consecutive disagreeing samples
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (btn_raw[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                cnt <= '0;
                lvl <= btn_raw[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign btn_lvl[i] = lvl;
    end
`else
    assign btn_lvl = btn_raw;
`endif

    // One-cycle button history for rising-edge (press) detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_lvl;
        end
    end

    assign press = btn_lvl & ~btn_q;

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    state_t  state;
    state_t  state_nxt;
    action_t action;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and prioritised action select (clr > pop > push > exec)
    always_comb begin
        state_nxt = state;
        action    = ACT_NONE;
        case (state)
            IDLE: begin
                if (|press) begin
                    state_nxt = HOLD;
                    if (press[BTN_CLR])       action = ACT_CLR;
                    else if (press[BTN_POP])  action = ACT_POP;
                    else if (press[BTN_PUSH]) action = ACT_PUSH;
                    else                      action = ACT_EXEC;
                end
            end
            HOLD: begin
                if (btn_lvl == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, stack and sticky error
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] alu_y;
    logic             alu_ovf;
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic             stack_full;
    logic             stack_empty;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [DW-1:0]    depth_m1;
    logic             do_push;

    calc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a   (acc),
        .b   (sw),
        .op  (op_sel),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    assign stack_full  = (depth == DW'(DEPTH));
    assign stack_empty = (depth == '0);
    assign depth_m1    = depth - 1'b1;
    assign wr_idx      = depth[AW-1:0];
    assign rd_idx      = depth_m1[AW-1:0];
    assign do_push     = (action == ACT_PUSH) && !stack_full;

    // Accumulator, occupancy and sticky error updated by the committed action
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else begin
            case (action)
                ACT_CLR: begin
                    acc   <= '0;
                    depth <= '0;
                    err   <= 1'b0;
                end
                ACT_POP: begin
                    if (stack_empty) begin
                        err <= 1'b1;
                    end else begin
                        acc   <= stack_mem[rd_idx];
                        depth <= depth_m1;
                    end
                end
                ACT_PUSH: begin
                    if (stack_full) begin
                        err <= 1'b1;
                    end else begin
                        depth <= depth + 1'b1;
                    end
                end
                ACT_EXEC: begin
                    acc <= alu_y;
                    if (alu_ovf) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stack storage; contents beyond the occupancy are don't-care
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[wr_idx] <= acc;
        end
    end

    assign led = acc;

endmodule
`default_nettype wire
